// File: rtl/axi_mst_traffic_gen.sv
//------------------------------------------------------------------------------
// Module  : axi_mst_traffic_gen
// Brief   : AXI3-style traffic master. On start it issues NUM_WR write bursts
//           and NUM_RD read bursts concurrently. Ids, lengths and payloads are
//           deterministic. Outstanding bursts are tracked in each direction.
// Macro   : AXI_MST_TRAFFIC_GEN_CHECK_EN - when defined, response ids, resp
//           codes and rlast placement are also checked and reported on err.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_mst_traffic_gen #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32,
  parameter int OSTD_NUM   = 4,
  parameter int NUM_WR     = 16,
  parameter int NUM_RD     = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  done,
  output logic                  err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_ID_W-1:0]   awid,
  output logic [3:0]            awlen,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [AXI_ID_W-1:0]   wid,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [AXI_ID_W-1:0]   bid,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [3:0]            arlen,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);

  localparam int               CNT_W    = $clog2(OSTD_NUM) + 1;
  localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(OSTD_NUM);
  localparam logic [7:0]       NUM_WR_C = 8'(NUM_WR);
  localparam logic [7:0]       NUM_RD_C = 8'(NUM_RD);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_ADDR = 2'd1;
  localparam logic [1:0] WR_DATA = 2'd2;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_ADDR = 1'b1;

  logic [1:0]       wr_state;
  logic [7:0]       wr_k;
  logic [3:0]       wr_beat;
  logic [CNT_W-1:0] wr_ostd;
  logic [0:0]       rd_state;
  logic [7:0]       rd_j;
  logic [CNT_W-1:0] rd_ostd;
  logic [7:0]       b_cnt;
  logic [7:0]       r_cnt;
  logic [7:0]       b_cnt_nxt;
  logic [7:0]       r_cnt_nxt;

  logic start_ok;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic b_ok, b_orphan, r_ok, r_orphan, r_pop;
  logic wr_final, rd_final;
  logic chk_err;
  logic unused_rsp;

  // A run may only be launched when both directions are quiescent.
  assign start_ok = start && (wr_state == WR_IDLE) && (rd_state == RD_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign b_hs  = bvalid && bready;
  assign r_hs  = rvalid && rready;

  // Responses only count when a burst is actually outstanding; others are errors.
  assign b_ok     = b_hs && (wr_ostd != '0);
  assign b_orphan = b_hs && (wr_ostd == '0);
  assign r_ok     = r_hs && (rd_ostd != '0);
  assign r_orphan = r_hs && (rd_ostd == '0);
  assign r_pop    = r_ok && rlast;

  assign wr_final = (wr_k == 8'(NUM_WR - 1));
  assign rd_final = (rd_j == 8'(NUM_RD - 1));

  // Write channel outputs are pure functions of the burst index and beat.
  assign awvalid = (wr_state == WR_ADDR) && (wr_ostd < OSTD_MAX);
  assign awid    = AXI_ID_W'(wr_k);
  assign awlen   = wr_k[3:0];
  assign wvalid  = (wr_state == WR_DATA);
  assign wid     = awid;
  assign wdata   = AXI_DATA_W'({wr_k, 4'h0, wr_beat});
  assign wlast   = wvalid && (wr_beat == awlen);

  // arlen = 3*j mod 16, computed in 4 bits so the wrap is free.
  assign arvalid = (rd_state == RD_ADDR) && (rd_ostd < OSTD_MAX);
  assign arid    = AXI_ID_W'(rd_j);
  assign arlen   = {rd_j[2:0], 1'b0} + rd_j[3:0];

  assign bready = aresetn;
  assign rready = aresetn;

  // Write FSM: address phase, then awlen+1 data beats, repeated NUM_WR times.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      wr_k     <= '0;
      wr_beat  <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (start_ok) begin
            wr_state <= WR_ADDR;
            wr_k     <= '0;
            wr_beat  <= '0;
          end
        end
        WR_ADDR: begin
          if (aw_hs) begin
            wr_state <= WR_DATA;
            wr_beat  <= '0;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            if (wlast) begin
              wr_beat  <= '0;
              wr_k     <= wr_k + 8'd1;
              wr_state <= wr_final ? WR_IDLE : WR_ADDR;
            end else begin
              wr_beat <= wr_beat + 4'd1;
            end
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read FSM: one address handshake per burst, NUM_RD bursts per run.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rd_j     <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (start_ok) begin
            rd_state <= RD_ADDR;
            rd_j     <= '0;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            rd_j     <= rd_j + 8'd1;
            rd_state <= rd_final ? RD_IDLE : RD_ADDR;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Outstanding-burst occupancy; simultaneous issue and retire cancel out.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ostd <= '0;
      rd_ostd <= '0;
    end else begin
      case ({w_hs && wlast, b_ok})
        2'b10:   wr_ostd <= wr_ostd + 1'b1;
        2'b01:   wr_ostd <= wr_ostd - 1'b1;
        default: wr_ostd <= wr_ostd;
      endcase
      case ({ar_hs, r_pop})
        2'b10:   rd_ostd <= rd_ostd + 1'b1;
        2'b01:   rd_ostd <= rd_ostd - 1'b1;
        default: rd_ostd <= rd_ostd;
      endcase
    end
  end

  assign b_cnt_nxt = start_ok ? 8'd0 : b_cnt + {7'd0, b_ok};
  assign r_cnt_nxt = start_ok ? 8'd0 : r_cnt + {7'd0, r_pop};

  // Completion counters, sticky done (cleared by start) and sticky err.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_cnt <= '0;
      r_cnt <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      b_cnt <= b_cnt_nxt;
      r_cnt <= r_cnt_nxt;
      done  <= !start_ok && (done || ((b_cnt_nxt == NUM_WR_C) && (r_cnt_nxt == NUM_RD_C)));
      err   <= err || b_orphan || r_orphan || chk_err;
    end
  end

`ifdef AXI_MST_TRAFFIC_GEN_CHECK_EN
  localparam int               PTR_W    = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OSTD_NUM - 1);

  logic [3:0]          fifo_len [OSTD_NUM];
  logic [AXI_ID_W-1:0] fifo_id  [OSTD_NUM];
  logic [PTR_W-1:0]    fifo_wptr;
  logic [PTR_W-1:0]    fifo_rptr;
  logic [3:0]          r_beat;

  // Remember length and id of every accepted read burst, in issue order.
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      fifo_len[fifo_wptr] <= arlen;
      fifo_id[fifo_wptr]  <= arid;
    end
  end

  // FIFO pointers and the beat position inside the current read burst.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_wptr <= '0;
      fifo_rptr <= '0;
      r_beat    <= '0;
    end else begin
      if (ar_hs) begin
        fifo_wptr <= (fifo_wptr == PTR_LAST) ? '0 : fifo_wptr + 1'b1;
      end
      if (r_pop) begin
        fifo_rptr <= (fifo_rptr == PTR_LAST) ? '0 : fifo_rptr + 1'b1;
      end
      if (r_ok) begin
        r_beat <= rlast ? 4'd0 : r_beat + 4'd1;
      end
    end
  end

  // Writes complete in order, so the expected bid is the completion count.
  assign chk_err = (b_ok && ((bid != AXI_ID_W'(b_cnt)) || (bresp != 2'b00))) ||
                   (r_ok && ((rid != fifo_id[fifo_rptr]) || (rresp != 2'b00) ||
                             (rlast != (r_beat == fifo_len[fifo_rptr]))));
  assign unused_rsp = ^rdata;
`else
  assign chk_err    = 1'b0;
  assign unused_rsp = ^{bid, bresp, rid, rresp, rdata};
`endif

endmodule

`default_nettype wire
